imm_operand_pipe: RTL and testbench

Parametrised, pipelined operand-formation stage for the MIPS datapath. It extends an immediate field in one of four modes and selects among NUM_SRC register-bus sources. The selected operand is registered behind a valid/ready handshake with a 2-entry skid buffer. It generalises the combinational sign-extender and 2-input muxes into one registered stage between decode and the ALU, so the stage can absorb one cycle of downstream stall without losing a beat.

---
 rtl/imm_operand_pipe.sv | 163 ++++++++++++++++
 tb/tb_imm_operand_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_operand_pipe.sv
// rtl/imm_operand_pipe.sv - registered immediate-extend / source-select operand stage with 2-entry skid
//
// Purpose:
//   Forms one ALU operand per beat. The operand is either the immediate,
//   extended in one of four modes, or one of NUM_SRC register-bus sources.
//   The operand and an out-of-range-select error flag are registered behind
//   a valid/ready handshake. A main register M drives the outputs and a skid
//   register S absorbs one beat while the consumer stalls.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is registered)
//   imm, ext_mode         raw immediate and extension mode
//                         (00 zero, 01 sign, 10 upper, 11 branch)
//   use_imm               1: operand = extended imm, 0: operand = src[src_sel]
//   src_sel, src_bus      source index and packed sources (k at [k*WIDTH +: WIDTH])
//   out_valid / out_ready downstream handshake
//   out_data, out_err     formed operand and out-of-range-select flag
module imm_operand_pipe #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int NUM_SRC   = 4,
    localparam int SEL_W    = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_WIDTH-1:0]     imm,
    input  logic [1:0]               ext_mode,
    input  logic                     use_imm,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_err_q, m_err_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             s_err_q, s_err_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] sext;
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;
    logic [WIDTH-1:0] beat_data;
    logic             beat_err;
    logic             accept;
    logic             drain;

    // Immediate extension
    always_comb begin
        sext = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
        unique case (ext_mode)
            2'b00:   ext = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
            2'b01:   ext = sext;
            2'b10:   ext = {imm, {(WIDTH-IMM_WIDTH){1'b0}}};
            default: ext = {sext[WIDTH-3:0], 2'b00};
        endcase
    end

    // Source mux; an index with no matching source leaves sel_data at zero
    // and sel_ok low, which is how an out-of-range select is detected.
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                sel_data = src_bus[k*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        beat_data = use_imm ? ext : sel_data;
        beat_err  = !use_imm && !sel_ok;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = m_data_q;
    assign out_err   = m_err_q;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid && out_ready;

    // Next state and storage updates
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_err_d  = m_err_q;
        s_data_d = s_data_q;
        s_err_d  = s_err_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    m_data_d = beat_data;
                    m_err_d  = beat_err;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    m_data_d = beat_data;
                    m_err_d  = beat_err;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    // M is still waiting for the consumer; park the new beat in S
                    state_d  = ST_TWO;
                    s_data_d = beat_data;
                    s_err_d  = beat_err;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d  = ST_ONE;
                    m_data_d = s_data_q;
                    m_err_d  = s_err_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Registered so that in_ready is a pure function of state and has no
        // combinational path from out_ready or in_valid.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            m_data_q   <= '0;
            m_err_q    <= 1'b0;
            s_data_q   <= '0;
            s_err_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_err_q    <= m_err_d;
            s_data_q   <= s_data_d;
            s_err_q    <= s_err_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_imm_operand_pipe.sv
// tb/tb_imm_operand_pipe.sv - self-checking bench for imm_operand_pipe
module tb_imm_operand_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [1:0]  ext_mode;
    logic        use_imm;
    logic [1:0]  src_sel;
    logic [95:0] src_bus;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    imm_operand_pipe #(
        .WIDTH    (32),
        .IMM_WIDTH(16),
        .NUM_SRC  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .imm      (imm),
        .ext_mode (ext_mode),
        .use_imm  (use_imm),
        .src_sel  (src_sel),
        .src_bus  (src_bus),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } log_t;

    logic [32:0] q[$];
    log_t        out_log[$];
    logic        rdy_ok;
    logic        exp_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {err, operand} for one beat, from plain arithmetic
    function automatic logic [32:0] model(input logic [15:0] i, input logic [1:0] m,
                                          input logic u, input logic [1:0] s,
                                          input logic [95:0] sb);
        int          sv;
        logic [31:0] e;
        sv = (i >= 16'h8000) ? int'(i) - 65536 : int'(i);
        case (m)
            2'd0:    e = 32'(i);
            2'd1:    e = 32'(sv);
            2'd2:    e = 32'(i) * 32'd65536;
            default: e = 32'(sv * 4);
        endcase
        if (u) return {1'b0, e};
        if (s < 2'd3) return {1'b0, sb[s*32 +: 32]};
        return {1'b1, 32'h0};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_ok <= 1'b0;
        else        rdy_ok <= 1'b1;
    end

    // Compare process: checks every cycle, then advances the model for the coming edge
    always @(negedge clk) begin
        log_t le;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_in_ready", in_ready, 1'b0);
        end else begin
            exp_rdy = rdy_ok && (q.size() < 2);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_data", out_data, q[0][31:0]);
                chk("out_err", out_err, q[0][32]);
                if (out_ready) begin
                    le.d = q[0][31:0];
                    le.c = cyc;
                    out_log.push_back(le);
                    void'(q.pop_front());
                end
            end
            if (in_valid && exp_rdy)
                q.push_back(model(imm, ext_mode, use_imm, src_sel, src_bus));
        end
    end

    task automatic direct(input string nm, input logic [15:0] i, input logic [1:0] m,
                          input logic u, input logic [1:0] s,
                          input logic [31:0] ed, input logic ee);
        @(posedge clk); #2;
        imm = i; ext_mode = m; use_imm = u; src_sel = s;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk(nm, out_data, ed);
        chk({nm, "_err"}, out_err, ee);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm = '0; ext_mode = '0; use_imm = 1'b0; src_sel = '0;
        src_bus = {32'hDEADBEEF, 32'h22222222, 32'h11111111};

        // Model pinned to hand-computed values
        chk("model_zero",   model(16'h8004, 2'd0, 1'b1, 2'd0, src_bus), {1'b0, 32'h00008004});
        chk("model_branch", model(16'h8004, 2'd3, 1'b1, 2'd0, src_bus), {1'b0, 32'hFFFE0010});
        chk("model_oor",    model(16'h0000, 2'd0, 1'b0, 2'd3, src_bus), {1'b1, 32'h00000000});

        #1;
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", in_ready, 1'b1);

        // Extension and selection, literal expectations
        direct("ext_zero",   16'h8004, 2'd0, 1'b1, 2'd0, 32'h00008004, 1'b0);
        direct("ext_sign",   16'h8004, 2'd1, 1'b1, 2'd0, 32'hFFFF8004, 1'b0);
        direct("ext_upper",  16'h8004, 2'd2, 1'b1, 2'd0, 32'h80040000, 1'b0);
        direct("ext_branch", 16'h8004, 2'd3, 1'b1, 2'd0, 32'hFFFE0010, 1'b0);
        direct("ext_sign_pos", 16'h7FFF, 2'd1, 1'b1, 2'd0, 32'h00007FFF, 1'b0);
        direct("sel2",       16'h0000, 2'd0, 1'b0, 2'd2, 32'hDEADBEEF, 1'b0);
        direct("sel0",       16'h0000, 2'd0, 1'b0, 2'd0, 32'h11111111, 1'b0);
        direct("sel3_oor",   16'h0000, 2'd0, 1'b0, 2'd3, 32'h00000000, 1'b1);
        direct("sel3_imm",   16'h8004, 2'd1, 1'b1, 2'd3, 32'hFFFF8004, 1'b0);

        // Backpressure: A, B accepted, C held upstream until the consumer resumes
        @(posedge clk); #2;
        out_log.delete();
        out_ready = 1'b0; in_valid = 1'b1; use_imm = 1'b1; ext_mode = 2'd0; imm = 16'h00A1;
        @(posedge clk); #2 imm = 16'h00B2;
        @(posedge clk); #2 imm = 16'h00C3;
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_hold_a", out_data, 32'h000000A1);
        repeat (3) begin
            @(posedge clk); #2;
            chk("bp_stable_a", out_data, 32'h000000A1);
            chk("bp_stable_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            @(negedge clk) acc = in_ready;
            @(posedge clk); #2;
            n++;
        end
        chk("bp_c_accepted", acc, 1'b1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("bp_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("bp_first",  out_log[0].d, 32'h000000A1);
            chk("bp_second", out_log[1].d, 32'h000000B2);
            chk("bp_third",  out_log[2].d, 32'h000000C3);
            chk("bp_consec", out_log[2].c - out_log[0].c, 2);
        end

        // Streaming: 8 back-to-back beats with the consumer always ready
        out_log.delete();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            in_valid = 1'b1; use_imm = 1'b1; ext_mode = 2'd0; imm = 16'(16'h0100 + i);
            chk("stream_ready", in_ready, 1'b1);
        end
        @(posedge clk); #2 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("stream_count", out_log.size(), 8);
        if (out_log.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("stream_data", out_log[i].d, 32'(32'h0100 + i));
            chk("stream_consec", out_log[7].c - out_log[0].c, 7);
        end

        // Reset while two beats are held
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; use_imm = 1'b1; ext_mode = 2'd0; imm = 16'h0AAA;
        @(posedge clk); #2 imm = 16'h0BBB;
        @(posedge clk); #2 in_valid = 1'b0;
        chk("two_ready_low", in_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 1'b0);
        chk("async_rst_data", out_data, 32'h0);
        chk("async_rst_err", out_err, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rerelease_ready", in_ready, 1'b1);
        direct("post_rst", 16'h1234, 2'd0, 1'b1, 2'd0, 32'h00001234, 1'b0);
        @(posedge clk); #2;
        chk("no_stale_valid", out_valid, 1'b0);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            imm       = 16'($urandom);
            ext_mode  = 2'($urandom);
            use_imm   = 1'($urandom);
            src_sel   = 2'($urandom);
            src_bus   = {$urandom, $urandom, $urandom};
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("final_drained", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
